// File: rtl/calc_port_resp.sv
// calc_port_resp: two-cycle request calculator with an in-order response FIFO
// Ports: c_clk   - rising-edge clock
//        reset   - synchronous, active-low
//        req_*   - command, operand1 and tag in the command cycle; operand2 in the next cycle
//        out_*   - one-cycle response {resp, data, tag}, all zero when idle
//        drop_err- sticky flag, a response was lost to FIFO overflow
// POP_HOLD inhibits popping for that many cycles after reset. It is 0 in normal
// use and exists so the FIFO can be filled to exercise the overflow path.
module calc_port_resp #(
    parameter int DEPTH    = 4,
    parameter int POP_HOLD = 0
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag,
    output logic        drop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [15:0] HOLD = 16'(POP_HOLD);

    typedef enum logic {IDLE, OP2} state_t;
    state_t state, state_nx;

    logic [3:0]    cmd_q;
    logic [31:0]   op1_q;
    logic [1:0]    tag_q;
    logic [35:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   hold_cnt;
    logic [32:0]   sum;
    logic [1:0]    res_resp;
    logic [31:0]   res_data;
    logic          push, pop, wr;

    always_comb begin
        state_nx = (state == IDLE && req_cmd_in != 4'b0000) ? OP2 : IDLE;
        sum      = {1'b0, op1_q} + {1'b0, req_data_in};
        res_resp = 2'b01;
        res_data = '0;
        case (cmd_q)
            4'b0001: if (sum[32]) res_resp = 2'b10; else res_data = sum[31:0];
            4'b0010: if (req_data_in > op1_q) res_resp = 2'b10; else res_data = op1_q - req_data_in;
            4'b0101: res_data = op1_q << req_data_in[4:0];
            4'b0110: res_data = op1_q >> req_data_in[4:0];
            default: res_resp = 2'b10;
        endcase
        push = state == OP2;
        pop  = count != '0 && hold_cnt == '0;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        wr   = push && (count != FULL || pop);
    end

    always_ff @(posedge c_clk) begin
        if (reset && wr)
            mem[wr_ptr] <= {res_resp, res_data, tag_q};
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state    <= IDLE;
            cmd_q    <= '0;
            op1_q    <= '0;
            tag_q    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_cnt <= HOLD;
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            drop_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_cmd_in != 4'b0000) begin
                cmd_q <= req_cmd_in;
                op1_q <= req_data_in;
                tag_q <= req_tag_in;
            end
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !wr)
                drop_err <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)
                count <= count + 1'b1;
            else if (pop && !wr)
                count <= count - 1'b1;
            if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
            {out_resp, out_data, out_tag} <= pop ? mem[rd_ptr] : 36'd0;
        end
    end
endmodule

// File: tb/tb_calc_port_resp.sv
// tb_calc_port_resp: directed bench for calc_port_resp with a request-level model
// dut drives the normal configuration; dut2 (DEPTH=2, pops held after reset)
// shares its stimulus and is only examined for the overflow scenario.
module tb_calc_port_resp;
    logic        c_clk;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp, out_resp2;
    logic [31:0] out_data, out_data2;
    logic [1:0]  out_tag, out_tag2;
    logic        drop_err, drop_err2;

    calc_port_resp #(.DEPTH(4)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_tag_in(req_tag_in), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .drop_err(drop_err)
    );

    calc_port_resp #(.DEPTH(2), .POP_HOLD(12)) dut2 (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .req_tag_in(req_tag_in), .out_resp(out_resp2), .out_data(out_data2), .out_tag(out_tag2),
        .drop_err(drop_err2)
    );

    typedef struct {
        int          c;
        int          sel;
        logic [36:0] v;
        string       name;
    } lit_t;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_on = 0;
    logic [35:0] exp_map [int];
    lit_t        lits [$];

    initial c_clk = 0;
    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    // Expected response of one request from the arithmetic rules alone.
    function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] tag);
        logic [63:0] x;
        bit          err;
        x   = '0;
        err = 0;
        case (cmd)
            4'd1: begin x = {32'd0, a} + {32'd0, b}; err = x > 64'hFFFF_FFFF; end
            4'd2: begin err = b > a; x = {32'd0, a} - {32'd0, b}; end
            4'd5: x = {32'd0, a} << (b % 32);
            4'd6: x = {32'd0, a} >> (b % 32);
            default: err = 1;
        endcase
        return err ? {2'b10, 32'd0, tag} : {2'b01, x[31:0], tag};
    endfunction

    function automatic logic [36:0] r(input logic d, input logic [1:0] resp, input logic [31:0] data,
                                      input logic [1:0] tag);
        return {d, resp, data, tag};
    endfunction

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    task automatic lit(input int c, input int sel, input logic [36:0] v, input string name);
        lits.push_back('{c, sel, v, name});
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag);
        exp_map[cyc + 3] = model(cmd, a, b, tag);
        req_cmd_in  = cmd;
        req_data_in = a;
        req_tag_in  = tag;
        step();
        req_cmd_in  = 4'hF;
        req_tag_in  = ~tag;
        req_data_in = b;
        step();
        req_cmd_in  = 4'h0;
        req_tag_in  = 2'd0;
        req_data_in = 32'hDEAD_BEEF;
    endtask

    task automatic single(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag,
                          input logic [36:0] v, input string name);
        int t;
        t = cyc;
        lit(t + 3, 0, v, name);
        lit(t + 4, 0, 37'd0, {name, "_gap"});
        send(cmd, a, b, tag);
        step();
        step();
    endtask

    always @(negedge c_clk) begin
        logic [36:0] a1, a2, e1, a;
        if (chk_on) begin
            a1 = {drop_err, out_resp, out_data, out_tag};
            a2 = {drop_err2, out_resp2, out_data2, out_tag2};
            e1 = {1'b0, exp_map.exists(cyc) ? exp_map[cyc] : 36'd0};
            total++;
            if (a1 !== e1) begin
                bad++;
                $display("FAIL model cyc=%0d got=%h want=%h", cyc, a1, e1);
            end
            for (int i = lits.size() - 1; i >= 0; i--) begin
                if (lits[i].c <= cyc) begin
                    a = lits[i].sel != 0 ? a2 : a1;
                    total++;
                    if (lits[i].c < cyc || a !== lits[i].v) begin
                        bad++;
                        $display("FAIL %s cyc=%0d got=%h want=%h", lits[i].name, lits[i].c, a, lits[i].v);
                    end
                    lits.delete(i);
                end
            end
        end
    end

    initial begin
        int t;
        reset       = 0;
        req_cmd_in  = 0;
        req_data_in = 0;
        req_tag_in  = 0;
        step();
        chk_on = 1;
        lit(cyc, 0, 37'd0, "reset_state");
        lit(cyc, 1, 37'd0, "reset_state2");
        step();
        reset = 1;
        step();

        single(4'b0001, 32'h5, 32'h3, 2'd2, r(0, 2'b01, 32'h8, 2'd2), "add");
        single(4'b0001, 32'hFFFF_FFFF, 32'h1, 2'd1, r(0, 2'b10, 32'h0, 2'd1), "add_ovf");
        single(4'b0010, 32'h3, 32'h5, 2'd0, r(0, 2'b10, 32'h0, 2'd0), "sub_udf");
        single(4'b0010, 32'hA, 32'h3, 2'd3, r(0, 2'b01, 32'h7, 2'd3), "sub");
        single(4'b1111, 32'h1234, 32'h1, 2'd2, r(0, 2'b10, 32'h0, 2'd2), "invalid_f");
        single(4'b0011, 32'h1234, 32'h1, 2'd3, r(0, 2'b10, 32'h0, 2'd3), "invalid_3");
        single(4'b0101, 32'h1, 32'h24, 2'd1, r(0, 2'b01, 32'h10, 2'd1), "shl");
        single(4'b0110, 32'h8000_0000, 32'h3F, 2'd0, r(0, 2'b01, 32'h1, 2'd0), "shr");

        t = cyc;
        lit(t + 3, 0, r(0, 2'b01, 32'h2, 2'd3), "order0");
        lit(t + 4, 0, 37'd0, "order_gap0");
        lit(t + 5, 0, r(0, 2'b01, 32'h5, 2'd0), "order1");
        lit(t + 6, 0, 37'd0, "order_gap1");
        lit(t + 7, 0, r(0, 2'b01, 32'h6, 2'd2), "order2");
        lit(t + 8, 0, 37'd0, "order_gap2");
        lit(t + 9, 0, r(0, 2'b01, 32'h10, 2'd1), "order3");
        lit(t + 10, 0, 37'd0, "order_gap3");
        send(4'b0001, 32'h1, 32'h1, 2'd3);
        send(4'b0010, 32'h9, 32'h4, 2'd0);
        send(4'b0101, 32'h3, 32'h1, 2'd2);
        send(4'b0110, 32'h100, 32'h4, 2'd1);
        repeat (6) step();

        t = cyc;
        req_cmd_in  = 4'b0001;
        req_data_in = 32'h7;
        req_tag_in  = 2'd1;
        step();
        req_data_in = 32'h9;
        reset       = 0;
        step();
        reset      = 1;
        req_cmd_in = 0;
        lit(t + 2, 0, 37'd0, "midop_reset");
        lit(t + 4, 0, 37'd0, "midop_no_resp");
        repeat (6) step();
        single(4'b0001, 32'h20, 32'h2, 2'd2, r(0, 2'b01, 32'h22, 2'd2), "after_reset");

        reset = 0;
        step();
        reset = 1;
        t = cyc;
        lit(t + 6, 1, r(1, 2'b00, 32'h0, 2'd0), "drop_set");
        lit(t + 12, 1, r(1, 2'b00, 32'h0, 2'd0), "drop_held");
        lit(t + 13, 1, r(1, 2'b01, 32'h2, 2'd1), "drop_keep0");
        lit(t + 14, 1, r(1, 2'b01, 32'h4, 2'd2), "drop_keep1");
        lit(t + 15, 1, r(1, 2'b00, 32'h0, 2'd0), "drop_lost");
        send(4'b0001, 32'h1, 32'h1, 2'd1);
        send(4'b0001, 32'h2, 32'h2, 2'd2);
        send(4'b0001, 32'h3, 32'h3, 2'd3);
        repeat (12) step();
        reset = 0;
        step();
        lit(cyc, 1, 37'd0, "drop_clear");
        lit(cyc, 0, 37'd0, "final_zero");
        reset = 1;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/calc_port_resp.md
CALC_PORT_RESP -- requirements
Module: calc_port_resp

Interface
REQ-001 Parameter: DEPTH, 4, response FIFO entries (power of two, >=2).
REQ-002 Port: c_clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-low reset, sampled on c_clk rising edge.
REQ-004 Port: req_cmd_in  input  4  command; 0000 = idle.
REQ-005 Port: req_data_in  input  32  operand1 in the command cycle, operand2 in the following cycle.
REQ-006 Port: req_tag_in  input  2  request tag, sampled in the command cycle only.
REQ-007 Port: out_resp  output  2  00 none, 01 success, 10 error (overflow, underflow or invalid command).
REQ-008 Port: out_data  output  32  result; 0 unless out_resp = 01.
REQ-009 Port: out_tag  output  2  tag of the request being answered; 0 when out_resp = 00.
REQ-010 Port: drop_err  output  1  sticky flag, set when a response is lost to FIFO overflow.

Function
REQ-011 The request FSM SHALL have two states: IDLE and OP2.
- IDLE, cmd != 0000: capture cmd, operand1 and tag; go to OP2.
- IDLE, cmd == 0000: stay in IDLE.
REQ-012 OP2 SHALL capture req_data_in as operand2, ignore req_cmd_in and req_tag_in, and return to IDLE unconditionally after one cycle.
REQ-013 Commands SHALL be decoded as follows; the arithmetic is 32-bit unsigned.
- 0001 add: resp 10 on carry-out.
- 0010 sub: resp 10 when operand2 > operand1.
- 0101 shift left: shift operand1 by the 5 least-significant bits of operand2, zero fill.
- 0110 shift right: shift operand1 by the 5 least-significant bits of operand2, zero fill.
- Any other non-zero code: resp 10, data 0.
REQ-014 Every error response SHALL carry out_data = 0 and the request's tag.
REQ-015 The result {resp, data, tag} SHALL be pushed into the FIFO on the clock edge that ends the OP2 cycle.
REQ-016 The FIFO head SHALL be popped into the output register every cycle the FIFO is non-empty; one response is presented per cycle.
REQ-017 Each response SHALL be driven for exactly one cycle; out_resp returns to 00 in the next cycle unless another entry is popped.
REQ-018 Responses SHALL emerge in request acceptance order, independent of tag value.
REQ-019 Minimum latency: command in cycle T, operand2 in T+1, out_resp valid in cycle T+3 when the FIFO was empty.
REQ-020 Back-to-back requests, with a new command in the cycle immediately after OP2, SHALL be accepted at one request every 2 cycles with no bubbles.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged; this is legal when the FIFO is full.
REQ-022 A push while the FIFO is full with no pop in the same cycle SHALL discard the new result, set drop_err and leave the FIFO contents intact.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH, with a separate occupancy count of 0..DEPTH.

Reset
REQ-024 While reset = 0 at a c_clk edge, the block SHALL clear its state:
- FSM to IDLE.
- FIFO pointers and count to 0.
- out_resp, out_data, out_tag to 0.
- drop_err to 0.
REQ-025 A reset asserted during OP2 SHALL abort the pending request with no response; the first response after reset is released corresponds to a command issued after release.
REQ-026 Inputs SHALL be ignored in the cycle reset is asserted.

Verification
REQ-027 Add: cmd 0001, op1 0x0000_0005, op2 0x0000_0003, tag 2 -> in cycle T+3, resp 01, data 0x0000_0008, tag 2, for one cycle only.
REQ-028 Overflow: add 0xFFFF_FFFF + 0x0000_0001, tag 1 -> resp 10, data 0, tag 1.
REQ-029 Underflow, invalid command and shifts:
- sub 3 - 5 -> resp 10.
- cmd 1111 -> resp 10.
- shl 0x0000_0001 by 0x0000_0024 -> resp 01, data 0x0000_0010 (shift amount 4).
REQ-030 Ordering: four back-to-back requests with tags 3, 0, 2, 1 -> four single-cycle responses in tag order 3, 0, 2, 1, two cycles apart.
REQ-031 Mid-operation reset: assert reset in the OP2 cycle of a request -> no response emerges; all outputs are 0 in the following cycle; drop_err = 0.
REQ-032 Overflow path: force the FIFO full (DEPTH = 2, stall test-mode pop via parameterised bench) with a push -> drop_err = 1, stored responses unchanged; drop_err remains 1 until reset.
